// File: rtl/gf_lut_arbiter.sv
// gf_lut_arbiter: round-robin sharing of one GF(2^8) power table
// among NUM_REQ requesters, with one response buffer per requester.
module gf_lut_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ-1:0][15:0] req_exp_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [NUM_REQ-1:0][7:0]  rsp_data_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [7:0]               lut_addr_o,
  input  logic [7:0]               lut_data_i,
  output logic                     busy_o
);

  logic                    r_pv;
  logic [TAG_W-1:0]        r_tag;
  logic [7:0]              r_addr;
  logic [TAG_W-1:0]        r_last;
  logic [NUM_REQ-1:0]      r_rsp_v;
  logic [NUM_REQ-1:0][7:0] r_rsp_d;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any;
  logic [TAG_W-1:0]   w_gidx;
  logic [15:0]        w_exp;
  logic [8:0]         w_sum;
  logic [7:0]         w_fold;
  logic [7:0]         w_red;

  function automatic logic [TAG_W-1:0] f_idx(
    input logic [TAG_W-1:0] base,
    input int               off
  );
    int t;
    t = int'(base) + off;
    if (t >= NUM_REQ) t = t - NUM_REQ;
    return TAG_W'(t);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_valid_i[i]
                & ~(r_pv & (r_tag == TAG_W'(i)))
                & (~r_rsp_v[i] | rsp_ready_i[i]);
    end
  end

  // Search starts one past the last grant and wraps.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_gnt  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_any && w_elig[f_idx(r_last, k)]) begin
        w_any  = 1'b1;
        w_gidx = f_idx(r_last, k);
      end
    end
    w_gnt[w_gidx] = w_any;
  end

  // End-around-carry fold gives e mod 255 (255 maps to 0).
  assign w_exp  = req_exp_i[w_gidx];
  assign w_sum  = {1'b0, w_exp[15:8]} + {1'b0, w_exp[7:0]};
  assign w_fold = w_sum[7:0] + {7'd0, w_sum[8]};
  assign w_red  = (w_fold == 8'hFF) ? 8'h00 : w_fold;

  assign req_ready_o = w_gnt & {NUM_REQ{rst_ni}};
  assign rsp_valid_o = r_rsp_v;
  assign rsp_data_o  = r_rsp_d;
  assign lut_addr_o  = r_addr;
  assign busy_o      = r_pv | (|r_rsp_v);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pv   <= 1'b0;
      r_tag  <= '0;
      r_addr <= '0;
      r_last <= TAG_W'(NUM_REQ - 1);
    end else begin
      r_pv <= w_any;
      if (w_any) begin
        r_tag  <= w_gidx;
        r_addr <= w_red;
        r_last <= w_gidx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_v <= '0;
      r_rsp_d <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_pv && (r_tag == TAG_W'(i))) begin
          r_rsp_v[i] <= 1'b1;
          r_rsp_d[i] <= lut_data_i;
        end else if (r_rsp_v[i] && rsp_ready_i[i]) begin
          r_rsp_v[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gf_lut_arbiter.sv
// Bench for gf_lut_arbiter: directed vectors on a 2-requester
// instance, reset and random traffic on a 4-requester instance.
module tb_gf_lut_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]       v2, rdy2, rv2, rr2;
  logic [1:0][15:0] e2;
  logic [1:0][7:0]  d2;
  logic [7:0]       a2, ld2;
  logic             b2;

  logic [3:0]       v4, rdy4, rv4, rr4;
  logic [3:0][15:0] e4;
  logic [3:0][7:0]  d4;
  logic [7:0]       a4, ld4;
  logic             b4;

  logic [7:0] lut [256];
  assign ld2 = lut[a2];
  assign ld4 = lut[a4];

  gf_lut_arbiter #(.NUM_REQ(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v2), .req_exp_i(e2), .req_ready_o(rdy2),
    .rsp_valid_o(rv2), .rsp_data_o(d2), .rsp_ready_i(rr2),
    .lut_addr_o(a2), .lut_data_i(ld2), .busy_o(b2)
  );

  gf_lut_arbiter #(.NUM_REQ(4)) u4 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v4), .req_exp_i(e4), .req_ready_o(rdy4),
    .rsp_valid_o(rv4), .rsp_data_o(d4), .rsp_ready_i(rr4),
    .lut_addr_o(a4), .lut_data_i(ld4), .busy_o(b4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          rq;
    logic [15:0] e;
    logic [7:0]  addr;
    logic [7:0]  data;
  } vec_t;

  vec_t vt [6];
  logic [7:0] exq [4][$];
  logic [3:0] acc;
  logic [7:0] lv;

  initial begin
    lv = 8'd1;
    for (int k = 0; k < 256; k++) begin
      lut[k] = lv;
      lv = lv[0] ? 8'(({1'b0, lv} ^ 9'h11D) >> 1) : (lv >> 1);
    end

    vt[0] = '{0, 16'd0,     8'd0,  8'd1};
    vt[1] = '{1, 16'd1,     8'd1,  8'd142};
    vt[2] = '{1, 16'd256,   8'd1,  8'd142};
    vt[3] = '{1, 16'd255,   8'd0,  8'd1};
    vt[4] = '{1, 16'd65535, 8'd0,  8'd1};
    vt[5] = '{1, 16'd300,   8'd45, 8'd89};

    rst_n = 1'b0;
    v2 = 2'b11; e2 = '0; rr2 = '0;
    v4 = 4'hF;  e4 = '0; rr4 = '0;
    step();
    step();
    chk("rst_ready2", 32'(rdy2), 0);
    chk("rst_ready4", 32'(rdy4), 0);
    chk("rst_busy", 32'(b2), 0);
    chk("rst_addr", 32'(a2), 0);
    chk("rst_rspv", 32'(rv2), 0);
    chk("rst_data", 32'(d2), 0);
    v2 = '0;
    v4 = '0;
    rst_n = 1'b1;
    step();

    foreach (vt[k]) begin
      v2 = 2'(1 << vt[k].rq);
      e2[vt[k].rq] = vt[k].e;
      rr2 = '0;
      #1;
      chk("vec_ready", 32'(rdy2), 32'(1 << vt[k].rq));
      step();
      v2 = '0;
      chk("vec_addr", 32'(a2), 32'(vt[k].addr));
      chk("vec_busy", 32'(b2), 1);
      chk("vec_rspv_n1", 32'(rv2), 0);
      step();
      chk("vec_rspv", 32'(rv2), 32'(1 << vt[k].rq));
      chk("vec_data", 32'(d2[vt[k].rq]), 32'(vt[k].data));
      step();
      chk("vec_hold_v", 32'(rv2), 32'(1 << vt[k].rq));
      chk("vec_hold_d", 32'(d2[vt[k].rq]), 32'(vt[k].data));
      rr2 = 2'(1 << vt[k].rq);
      step();
      chk("vec_drain_v", 32'(rv2), 0);
      chk("vec_drain_busy", 32'(b2), 0);
      rr2 = '0;
    end

    // contention: grants alternate, responses alternate
    e2[0] = 16'd1;
    e2[1] = 16'd2;
    rr2 = 2'b11;
    v2 = 2'b11;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("cont_ready", 32'(rdy2), (c % 2 == 0) ? 1 : 2);
      if (c >= 2) begin
        chk("cont_rspv", 32'(rv2), (c % 2 == 0) ? 1 : 2);
        if (c % 2 == 0) chk("cont_d0", 32'(d2[0]), 142);
        else            chk("cont_d1", 32'(d2[1]), 71);
      end else begin
        chk("cont_rspv0", 32'(rv2), 0);
      end
      step();
    end
    v2 = '0;
    step();
    step();
    step();
    chk("cont_idle", 32'(b2), 0);

    // backpressure on requester 0
    e2[0] = 16'd300;
    e2[1] = 16'd256;
    rr2 = 2'b10;
    v2 = 2'b11;
    for (int c = 0; c < 7; c++) begin
      #1;
      chk("bp_ready", 32'(rdy2),
          (c == 0) ? 1 : ((c % 2 == 1) ? 2 : 0));
      if (c >= 2) begin
        chk("bp_v0", 32'(rv2[0]), 1);
        chk("bp_d0", 32'(d2[0]), 89);
      end
      step();
    end
    rr2 = 2'b11;
    #1;
    chk("bp_release", 32'(rdy2), 1);
    step();
    v2 = 2'b10;
    #1;
    chk("bp_after", 32'(rdy2), 2);
    step();
    v2 = '0;
    for (int c = 0; c < 4; c++) step();
    chk("bp_idle", 32'(b2), 0);

    // reset with pipe and two buffers occupied
    rr4 = '0;
    e4[0] = 16'd1;
    e4[1] = 16'd2;
    e4[2] = 16'd300;
    v4 = 4'b0111;
    #1;
    chk("mr_g0", 32'(rdy4), 1);
    step();
    v4 = 4'b0110;
    #1;
    chk("mr_g1", 32'(rdy4), 2);
    step();
    v4 = 4'b0100;
    #1;
    chk("mr_g2", 32'(rdy4), 4);
    step();
    v4 = '0;
    chk("mr_pre_v", 32'(rv4), 3);
    chk("mr_pre_a", 32'(a4), 45);
    rst_n = 1'b0;
    v4 = 4'hF;
    #1;
    chk("mr_rspv", 32'(rv4), 0);
    chk("mr_data", 32'(d4), 0);
    chk("mr_addr", 32'(a4), 0);
    chk("mr_busy", 32'(b4), 0);
    chk("mr_ready", 32'(rdy4), 0);
    step();
    v4 = '0;
    rst_n = 1'b1;
    rr4 = 4'hF;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("mr_post_v", 32'(rv4), 0);
      chk("mr_post_b", 32'(b4), 0);
      step();
    end

    // random traffic on the 4-requester instance
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!v4[i] && $urandom_range(0, 2) == 0) begin
          v4[i] = 1'b1;
          if ($urandom_range(0, 5) == 0)
            e4[i] = 16'(255 * $urandom_range(0, 257));
          else
            e4[i] = 16'($urandom);
        end
      end
      rr4 = 4'($urandom);
      #1;
      chk("rnd_onehot", 32'($onehot0(rdy4)), 1);
      chk("rnd_gnt_v", 32'(rdy4 & ~v4), 0);
      for (int i = 0; i < 4; i++) begin
        if (rv4[i] && rr4[i]) begin
          if (exq[i].size() == 0) chk("rnd_extra_rsp", 1, 0);
          else chk("rnd_data", 32'(d4[i]), 32'(exq[i].pop_front()));
        end
      end
      acc = v4 & rdy4;
      for (int i = 0; i < 4; i++)
        if (acc[i]) exq[i].push_back(lut[e4[i] % 255]);
      step();
      v4 = v4 & ~acc;
    end
    v4 = '0;
    rr4 = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      for (int i = 0; i < 4; i++) begin
        if (rv4[i]) begin
          if (exq[i].size() == 0) chk("drain_extra_rsp", 1, 0);
          else chk("drain_data", 32'(d4[i]), 32'(exq[i].pop_front()));
        end
      end
      step();
    end
    chk("rnd_idle", 32'(b4), 0);
    for (int i = 0; i < 4; i++)
      chk("rnd_missing_rsp", 32'(exq[i].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gf_lut_arbiter.md
# gf_lut_arbiter

Round-robin arbiter and sequencer that shares one GF(2^8) degree-sequence lookup table (power table, index k in 0..255) between NUM_REQ requesters. Each requester submits a 16-bit exponent. The block reduces it mod 255, drives the shared table address, captures the table output and returns it on a per-requester response channel. It sits between the GF arithmetic units (inverter, exponentiator) and the single combinational table instance, which is placed outside this block.

## Interface
Parameters:
- NUM_REQ, default 2, number of requesters, legal range 2..8.
- TAG_W, default $clog2(NUM_REQ), width of the internal requester tag. Derived; not overridden.

Ports:
- clk_i, in, 1, single clock; all state updates on the rising edge.
- rst_ni, in, 1, reset; asynchronous, active-low.
- req_valid_i, in, NUM_REQ, per-requester request valid.
- req_exp_i, in, NUM_REQ x 16, per-requester exponent; any 16-bit value is legal.
- req_ready_o, out, NUM_REQ, grant; at most one bit high per cycle.
- rsp_valid_o, out, NUM_REQ, per-requester response valid.
- rsp_data_o, out, NUM_REQ x 8, per-requester table value.
- rsp_ready_i, in, NUM_REQ, per-requester response accept.
- lut_addr_o, out, 8, registered address to the shared table.
- lut_data_i, in, 8, combinational table output for lut_addr_o.
- busy_o, out, 1, high while the pipe stage or any response buffer holds data.

## Operation
- Handshake: a request transfers in a cycle where req_valid_i[i] and req_ready_o[i] are both high. A response transfers in a cycle where rsp_valid_o[i] and rsp_ready_i[i] are both high.
- Request-side rules:
  - req_valid_i must stay high, with req_exp_i stable, until the request is accepted.
  - req_ready_o is combinational from req_valid_i and block state.
- Eligibility: requester i is eligible when all of the following hold:
  - req_valid_i[i] = 1;
  - the pipe stage does not hold tag i;
  - rsp_valid_o[i] = 0, or rsp_ready_i[i] = 1 in the same cycle.
- Arbitration: round-robin over the eligible requesters.
  - Search starts at last_grant+1 and wraps modulo NUM_REQ.
  - last_grant updates only on a grant.
  - Reset value of last_grant is NUM_REQ-1, so requester 0 has first priority.
- Reduction, combinational in the grant cycle:
  - s = e[15:8] + e[7:0] (9 bits);
  - r = s[7:0] + s[8] (8 bits, cannot overflow);
  - if r == 255 then r = 0.
  - Result is always in 0..254.
- Pipe stage, one entry: {valid, tag, addr}. Loaded on a grant; cleared when no grant occurs. lut_addr_o = addr.
- Response buffers: one entry per requester.
  - Buffer[tag] loads lut_data_i when the pipe entry is valid.
  - Buffer i clears on its response handshake unless it is reloaded in the same cycle; reload takes priority.
- busy_o = pipe valid OR any rsp_valid_o.
- No FSM beyond the pipe/buffer valids: the block is idle when busy_o = 0.

## Timing
- Reset (asynchronous, rst_ni low):
  - pipe valid = 0, lut_addr_o = 0;
  - all rsp_valid_o = 0, all rsp_data_o = 0;
  - last_grant = NUM_REQ-1, busy_o = 0.
  - req_ready_o is 0 throughout reset.
- Reset mid-operation discards in-flight and buffered results. No response appears after release for requests accepted before reset.
- Latency: handshake in cycle N; lut_addr_o valid in cycle N+1; rsp_valid_o[i] high from cycle N+2.
- Throughput:
  - one grant per cycle across all requesters;
  - one grant per 2 cycles for a single requester with rsp_ready_i held high.
- Backpressure: while rsp_ready_i[i] = 0 with a held response, requester i gets no grant; other requesters are unaffected.
- Simultaneous drain and grant for the same requester in cycle N is legal. The new result lands in cycle N+2 with no bubble in rsp_valid_o beyond cycle N+1.
- rsp_data_o[i] holds its value while rsp_valid_o[i] = 1 and the response is not accepted.

## Test plan
- Reset, then a single request from requester 0 with e=0 -> lut_addr_o=0 in cycle N+1; rsp_valid_o[0]=1, rsp_data_o[0]=1 in cycle N+2; busy_o returns to 0 after the drain.
- Reduction sweep through requester 1: e=1 -> 142; e=256 -> address 1 -> 142; e=255 -> address 0 -> 1; e=65535 -> address 0 -> 1; e=300 -> address 45 -> 89.
- Contention: both requesters hold valid, all rsp_ready_i=1 -> grants alternate 0,1,0,1 on consecutive cycles; first grant goes to 0; one response per cycle alternating.
- Backpressure: rsp_ready_i[0]=0 with a response held -> req_ready_o[0] stays 0 and rsp_data_o[0] stays stable; requester 1 is granted every other cycle. Raising rsp_ready_i[0] -> requester 0 is granted in that same cycle.
- Reset mid-operation: pull rst_ni low while the pipe and both buffers are full -> all outputs take reset values immediately; after release there is no rsp_valid_o until new requests are made.
- Random: NUM_REQ=4, random valids, exponents and rsp_ready_i -> every response matches the table at e mod 255, responses stay in order per requester, and at most one req_ready_o is high per cycle.
